onchip_memory_arbiter: RTL and testbench
========================================

# onchip_memory_arbiter

Two-requester round-robin arbiter that shares the single-port 8192 x 32 on-chip RAM (byte-enabled, one-cycle read latency, unregistered output) between two Avalon-MM masters, e.g. the HPS lightweight bridge and an FPGA-side DMA. It sits between the masters and the RAM's s1 port, issues at most one access per cycle, and returns read data with a per-master valid strobe. An optional post-reset scrub zeroes the whole RAM before any master is served.

## Interface
- ADDR_W, 13, word address width (RAM depth 2^ADDR_W)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- m0_address / m1_address  in  ADDR_W  requester word address
- m0_byteenable / m1_byteenable  in  DATA_W/8  write byte lanes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  high = request not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data, qualified by readdatavalid
- m0_readdatavalid / m1_readdatavalid  out  1  one-cycle read-return strobe
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  DATA_W/8  RAM byte enables
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable, constant 1
- mem_readdata  in  DATA_W  RAM read data, valid one cycle after the accepted read

## Operation
- FSM states: CLEAR (scrub, only with the macro), RUN. Reset enters CLEAR if the macro is defined, otherwise RUN.
- RUN: req_x = mx_read | mx_write. A master is granted when it alone requests, or when both request and it was not the last granted master.
- last_grant register: reset 1, so m0 wins the first contention. It updates to the winner on every grant, including uncontended ones.
- The winner's address, byteenable and writedata drive mem_*. mem_chipselect = 1 and mem_write = winner's write. The winner's waitrequest is 0 in the same cycle; the loser's waitrequest is 1.
- waitrequest_x = ~grant_x at all times, so it is 1 when idle, during CLEAR, and during reset.
- Read and write asserted together by one master are treated as a write; the read is dropped.
- A granted read sets rd_pend = 1 and rd_owner = x at the clock edge. In the next cycle mx_readdatavalid = 1 for the owner and mx_readdata = mem_readdata. Both readdata outputs are wired to mem_readdata.
- With no grant: mem_chipselect = 0, mem_write = 0, mem_byteenable = 0, and the address holds its last value.
- A new grant may be issued in the same cycle as a read return, giving full throughput of one access per cycle.
- Masters hold their request stable while waitrequest is 1 (Avalon rule); the arbiter does not latch requests.

## Timing
- Reset values: last_grant = 1, rd_pend = 0, both readdatavalid = 0, mem_chipselect = 0, mem_write = 0, clear counter = 0. mem_clken is constant 1.
- Write: accepted at edge N and in RAM after edge N. A read of the same address accepted at edge N+1 returns the new data.
- Read latency: request accepted at edge N, readdatavalid high in the cycle after edge N, for exactly one cycle.
- A master that wins contention loses the next contended cycle, so alternation is guaranteed and the maximum wait is 1 cycle.
- Reset asserted mid-operation: any pending readdatavalid is cancelled immediately (asynchronous reset). A write in flight at the reset edge is undefined in RAM.

## Configuration
- ONCHIP_ARB_CLEAR_EN defined:
  - After reset the FSM sits in CLEAR and writes 0 to addresses 0..2^ADDR_W-1, one per cycle, with byteenable all-ones and both waitrequests high.
  - When the counter reaches 2^ADDR_W-1, that last write is issued and the FSM enters RUN on the next edge. The scrub takes exactly 2^ADDR_W cycles (8192 by default).
  - Reset during CLEAR restarts the scrub at address 0.
- ONCHIP_ARB_CLEAR_EN undefined: no CLEAR state or counter exist; RUN is entered directly from reset and the RAM keeps its init-file contents.

## Test plan
- Reset release, m0 reads address 0x0005 (init word 0x1234_5678) -> m0_waitrequest = 0 on the request cycle; one cycle later m0_readdatavalid = 1, m0_readdata = 0x1234_5678, m1_readdatavalid = 0.
- m1 writes 0xDEAD_BEEF to 0x1FFF with byteenable 0x3, then reads 0x1FFF (old word 0xAAAA_AAAA) -> returns 0xAAAA_BEEF with a 1-cycle latency.
- Both masters hold continuous reads for 6 cycles -> grants go m0, m1, m0, m1, m0, m1; each readdatavalid strobes 3 times; mem_chipselect stays high throughout.
- m0 asserts read and write together at 0x0010 with 0x0000_0001 -> write performed, no m0_readdatavalid; a later read of 0x0010 returns 0x0000_0001.
- Reset asserted in the cycle after a granted read -> no readdatavalid; after release the first contention goes to m0.
- With ONCHIP_ARB_CLEAR_EN: requests during the scrub are held off for 8192 cycles; a read of 0x0005 afterwards returns 0x0000_0000. Reset at scrub address 0x0800 restarts the scrub at 0.

Source files
------------

// File: rtl/onchip_memory_arbiter_if.sv
// rtl/onchip_memory_arbiter_if.sv - Avalon-MM master bus between one requester and the arbiter
interface onchip_memory_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_memory_arbiter.sv
// rtl/onchip_memory_arbiter.sv - two-master round-robin arbiter for a single-port on-chip RAM
// Optional post-reset RAM scrub enabled by defining ONCHIP_ARB_CLEAR_EN.
module onchip_memory_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    onchip_memory_arbiter_if.slave m0,
    onchip_memory_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);
    logic              req0, req1, grant0, grant1, run;
    logic              last_grant, rd_pend, rd_owner;
    logic [ADDR_W-1:0] addr_q;

`ifdef ONCHIP_ARB_CLEAR_EN
    typedef enum logic {CLEAR, RUN} state_t;
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= CLEAR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == {ADDR_W{1'b1}})
            state_nxt = RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               clr_cnt <= '0;
        else if (state == CLEAR) clr_cnt <= clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
    end

    assign run = (state == RUN);
`else
    assign run = 1'b1;
`endif

    assign req0   = m0.read | m0.write;
    assign req1   = m1.read | m1.write;
    // last_grant holds the index of the previous winner; the other master wins a tie
    assign grant0 = run & req0 & (~req1 | last_grant);
    assign grant1 = run & req1 & (~req0 | ~last_grant);

    assign m0.waitrequest   = ~grant0;
    assign m1.waitrequest   = ~grant1;
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;
    assign m0.readdatavalid = rd_pend & ~rd_owner;
    assign m1.readdatavalid = rd_pend & rd_owner;
    assign mem_clken        = 1'b1;

    always_comb begin
        mem_address    = addr_q;
        mem_byteenable = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        if (grant0) begin
            mem_address    = m0.address;
            mem_byteenable = m0.byteenable;
            mem_chipselect = 1'b1;
            mem_write      = m0.write;
            mem_writedata  = m0.writedata;
        end else if (grant1) begin
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_chipselect = 1'b1;
            mem_write      = m1.write;
            mem_writedata  = m1.writedata;
        end
`ifdef ONCHIP_ARB_CLEAR_EN
        if (state == CLEAR) begin
            mem_address    = clr_cnt;
            mem_byteenable = '1;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
        end
`endif
    end

    // A write wins over a simultaneous read from the same master, so only pure reads return data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
        end else begin
            rd_pend <= (grant0 & ~m0.write) | (grant1 & ~m1.write);
            if (grant0 | grant1) begin
                rd_owner   <= grant1;
                last_grant <= grant1;
            end
            addr_q <= mem_address;
        end
    end
endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// tb/tb_onchip_memory_arbiter.sv - scoreboard bench for onchip_memory_arbiter with a behavioural RAM
module tb_onchip_memory_arbiter;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } ret_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata = '0;
    logic [31:0]       ram [0:8191];

    ret_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    onchip_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
    onchip_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();

    onchip_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .m0(m0_bus), .m1(m1_bus),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        ret_t e;
        if (m0_bus.readdatavalid || m1_bus.readdatavalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_readdatavalid", {30'd0, m1_bus.readdatavalid, m0_bus.readdatavalid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rdv_owner", {30'd0, m1_bus.readdatavalid, m0_bus.readdatavalid}, e.owner ? 32'd2 : 32'd1);
                check("readdata", e.owner ? m1_bus.readdata : m0_bus.readdata, e.data);
            end
        end
    end

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = '0;
        ram[13'h0005] = 32'h1234_5678;
        ram[13'h1FFF] = 32'hAAAA_AAAA;
        ram[13'h0020] = 32'h1111_0000;
        ram[13'h0021] = 32'h2222_0000;
        m0_bus.address = '0; m0_bus.byteenable = '0; m0_bus.read = 0; m0_bus.write = 0; m0_bus.writedata = '0;
        m1_bus.address = '0; m1_bus.byteenable = '0; m1_bus.read = 0; m1_bus.write = 0; m1_bus.writedata = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m0_wait", {31'd0, m0_bus.waitrequest}, 32'd1);
        check("rst_m1_wait", {31'd0, m1_bus.waitrequest}, 32'd1);
        check("rst_cs", {31'd0, mem_chipselect}, 32'd0);
        check("rst_wr", {31'd0, mem_write}, 32'd0);
        check("rst_rdv", {30'd0, m1_bus.readdatavalid, m0_bus.readdatavalid}, 32'd0);
        check("clken", {31'd0, mem_clken}, 32'd1);

        // m0 single read of init word
        step();
        reset = 1'b0;
        m0_bus.address = 13'h0005; m0_bus.read = 1'b1;
        @(negedge clk);
        check("rd5_m0_wait", {31'd0, m0_bus.waitrequest}, 32'd0);
        check("rd5_addr", {19'd0, mem_address}, 32'h0005);
        check("rd5_cs", {31'd0, mem_chipselect}, 32'd1);
        exp_q.push_back('{owner: 1'b0, data: 32'h1234_5678});
        step();
        m0_bus.read = 1'b0;
        @(negedge clk);
        check("idle_cs", {31'd0, mem_chipselect}, 32'd0);
        check("idle_be", {28'd0, mem_byteenable}, 32'd0);
        check("idle_addr_hold", {19'd0, mem_address}, 32'h0005);
        check("idle_m0_wait", {31'd0, m0_bus.waitrequest}, 32'd1);

        // m1 partial write then readback on the very next cycle
        step();
        m1_bus.address = 13'h1FFF; m1_bus.write = 1'b1; m1_bus.byteenable = 4'h3; m1_bus.writedata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("wr_m1_wait", {31'd0, m1_bus.waitrequest}, 32'd0);
        check("wr_mem_write", {31'd0, mem_write}, 32'd1);
        check("wr_be", {28'd0, mem_byteenable}, 32'h3);
        step();
        m1_bus.write = 1'b0; m1_bus.read = 1'b1;
        @(negedge clk);
        check("rb_m1_wait", {31'd0, m1_bus.waitrequest}, 32'd0);
        exp_q.push_back('{owner: 1'b1, data: 32'hAAAA_BEEF});
        step();
        m1_bus.read = 1'b0;

        // sustained contention alternates starting with m0
        m0_bus.address = 13'h0020; m0_bus.read = 1'b1;
        m1_bus.address = 13'h0021; m1_bus.read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_m0_wait", {31'd0, m0_bus.waitrequest}, (i % 2 == 0) ? 32'd0 : 32'd1);
            check("rr_m1_wait", {31'd0, m1_bus.waitrequest}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_cs", {31'd0, mem_chipselect}, 32'd1);
            if (i % 2 == 0) exp_q.push_back('{owner: 1'b0, data: 32'h1111_0000});
            else            exp_q.push_back('{owner: 1'b1, data: 32'h2222_0000});
            step();
        end
        m0_bus.read = 1'b0; m1_bus.read = 1'b0;

        // read+write together behaves as a write
        m0_bus.address = 13'h0010; m0_bus.read = 1'b1; m0_bus.write = 1'b1;
        m0_bus.byteenable = 4'hF; m0_bus.writedata = 32'h0000_0001;
        @(negedge clk);
        check("rw_wait", {31'd0, m0_bus.waitrequest}, 32'd0);
        check("rw_mem_write", {31'd0, mem_write}, 32'd1);
        step();
        m0_bus.write = 1'b0; m0_bus.read = 1'b0;
        step();
        m0_bus.read = 1'b1;
        @(negedge clk);
        exp_q.push_back('{owner: 1'b0, data: 32'h0000_0001});
        step();
        m0_bus.read = 1'b0;
        step();

        // reset right after a granted read cancels the return and restores m0 priority
        m0_bus.address = 13'h0005; m0_bus.read = 1'b1;
        @(negedge clk);
        check("rr_pre_wait", {31'd0, m0_bus.waitrequest}, 32'd0);
        step();
        m0_bus.read = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_cancel_rdv", {30'd0, m1_bus.readdatavalid, m0_bus.readdatavalid}, 32'd0);
        step();
        step();
        reset = 1'b0;
        m0_bus.address = 13'h0020; m0_bus.read = 1'b1;
        m1_bus.address = 13'h0021; m1_bus.read = 1'b1;
        @(negedge clk);
        check("post_rst_m0_wait", {31'd0, m0_bus.waitrequest}, 32'd0);
        check("post_rst_m1_wait", {31'd0, m1_bus.waitrequest}, 32'd1);
        exp_q.push_back('{owner: 1'b0, data: 32'h1111_0000});
        step();
        m0_bus.read = 1'b0;
        @(negedge clk);
        check("post_rst_m1_grant", {31'd0, m1_bus.waitrequest}, 32'd0);
        exp_q.push_back('{owner: 1'b1, data: 32'h2222_0000});
        step();
        m1_bus.read = 1'b0;
        repeat (3) step();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
